game_board_memory: RTL and testbench
====================================

# game_board_memory

Parametrised N×N game-board state store for the VGA game designs. It generalises the fixed 3×3, 2-bit tic-tac-toe board memory with configurable board size and cell width. It adds a registered read port for the renderer, guarded writes (occupied or out-of-range cells are rejected), an occupancy counter, a sequential clear sweep, and a win checker that runs after every accepted move. It sits between the game controller (write side) and the pixel renderer (read side).

## Interface
- N, 3: board side length, legal range 3..8; board holds N*N cells, index = row*N + col.
- CELL_W, 2: bits per cell; value 0 = empty, any non-zero value = player code.
- ADDR_W, $clog2(N*N) (derived localparam): cell index width.
- CNT_W, $clog2(N*N+1) (derived localparam): occupancy count width.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- wr_req  in  1  move request, sampled each rising edge.
- wr_addr  in  ADDR_W  target cell index.
- wr_data  in  CELL_W  player code to place.
- wr_ack  out  1  one-cycle pulse: move accepted.
- wr_err  out  1  one-cycle pulse: move rejected.
- clr  in  1  start a board clear sweep.
- rd_addr  in  ADDR_W  renderer read index.
- rd_data  out  CELL_W  registered cell value.
- busy  out  1  high while in CHECK or CLEAR.
- count  out  CNT_W  number of non-empty cells.
- full  out  1  count == N*N.
- check_done  out  1  one-cycle pulse when a win check completes.
- win_valid  out  1  sticky: a player has completed a line.
- win_player  out  CELL_W  code of the winning player; 0 when win_valid=0.

## Operation
- FSM states: IDLE, CHECK, CLEAR.
- IDLE:
  - clr=1: go to CLEAR. clr has priority over wr_req in the same cycle.
  - wr_req=1: accepted only if all four hold: wr_addr < N*N, wr_data != 0, the target cell is empty, and win_valid=0.
    - Accept: write the cell, count+1, pulse wr_ack, latch row/col/player, go to CHECK.
    - Reject: pulse wr_err; no state change.
- wr_req while busy=1: wr_err, write ignored.
- CHECK: scans 4 lines in the fixed order row, column, main diagonal, anti-diagonal.
  - Each line takes exactly N cycles, one cell per cycle, so CHECK always lasts 4*N cycles.
  - A diagonal that does not pass through the written cell (r!=c for the main diagonal, r+c!=N-1 for the anti-diagonal) is scanned but forced to no-match.
  - A line matches if all N cells equal the latched player.
  - On the final cycle: pulse check_done; if any line matched, set win_valid=1 and win_player=player. Return to IDLE.
  - clr during CHECK aborts the check: go to CLEAR with no check_done pulse.
- CLEAR: on entry, win_valid=0 and win_player=0.
  - Writes 0 to cell i for i = 0..N*N-1, one cell per cycle (N*N cycles).
  - Then count=0, return to IDLE. clr during CLEAR is ignored.
- Read port: rd_data <= cell[rd_addr] every cycle in all states. rd_addr >= N*N returns 0.
- count saturates at N*N; it never wraps.

## Timing
- Reset (reset=0) takes effect immediately, asynchronously, at any point including mid-CHECK or mid-CLEAR. Reset values:
  - all cells 0, FSM=IDLE;
  - rd_data=0, count=0, full=0, busy=0;
  - wr_ack=0, wr_err=0, check_done=0, win_valid=0, win_player=0.
- A wr_req sampled at edge k produces wr_ack or wr_err during cycle k+1. On accept, the cell update and busy=1 also take effect at edge k.
- check_done and win flags appear at edge k+4N; busy falls at the same edge.
- Read latency 1 cycle. A read of a cell written at the same edge returns the old value.
- A clr sampled at edge k gives busy=1 from edge k for N*N cycles. At edge k+N*N, busy=0 and count=0.
- full is combinational from count.

## Test plan
- Release reset, then read all indices 0..8 (N=3) -> rd_data=0 one cycle later; count=0, full=0, busy=0, win_valid=0.
- Write addr 4 data 1 -> wr_ack next cycle; rd_addr 4 -> 1; count=1; busy high exactly 12 cycles; check_done pulse with win_valid=0.
- Rewrite addr 4 data 2 -> wr_err, cell stays 1. Addr 9 -> wr_err. Data 0 -> wr_err. Any wr_req while busy -> wr_err. count unchanged throughout.
- Player 1 at 0, then 4, then 8 (waiting for busy to drop each time) -> after the third check, win_valid=1, win_player=1. Next write to addr 1 -> wr_err. Repeat on the anti-diagonal 2/4/6 and on row 3/4/5.
- Fill all 9 cells in a draw pattern -> count=9, full=1, win_valid=0.
- Assert clr mid-CHECK -> no check_done; busy 9 cycles; all cells 0, count=0, win cleared. Then assert reset=0 mid-CLEAR -> all outputs at reset values immediately.

Source files
------------

// File: rtl/game_board_memory_if.sv
// Board memory bus: controller move/clear side, renderer read side
// and board status flags.
interface game_board_memory_if #(
    parameter int N = 3,
    parameter int CELL_W = 2
);
    localparam int ADDR_W = $clog2(N * N);
    localparam int CNT_W = $clog2(N * N + 1);

    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [CELL_W-1:0] wr_data;
    logic              wr_ack;
    logic              wr_err;
    logic              clr;
    logic [ADDR_W-1:0] rd_addr;
    logic [CELL_W-1:0] rd_data;
    logic              busy;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              check_done;
    logic              win_valid;
    logic [CELL_W-1:0] win_player;

    modport master (
        output wr_req, wr_addr, wr_data, clr, rd_addr,
        input  wr_ack, wr_err, rd_data, busy, count, full,
        input  check_done, win_valid, win_player
    );

    modport slave (
        input  wr_req, wr_addr, wr_data, clr, rd_addr,
        output wr_ack, wr_err, rd_data, busy, count, full,
        output check_done, win_valid, win_player
    );
endinterface

// File: rtl/game_board_memory.sv
// N x N game board store with guarded moves, occupancy count,
// sequential clear sweep and a post-move win checker.
module game_board_memory #(
    parameter int N = 3,
    parameter int CELL_W = 2
) (
    input logic                clk,
    input logic                reset,
    game_board_memory_if.slave bus
);
    localparam int CELLS = N * N;
    localparam int ADDR_W = $clog2(CELLS);
    localparam int CNT_W = $clog2(CELLS + 1);
    localparam int IDX_W = $clog2(N);

    typedef enum logic [1:0] {IDLE, CHECK, CLEAR} state_t;

    state_t            state;
    logic [CELL_W-1:0] cells [CELLS];
    logic [CELL_W-1:0] rd_data;
    logic [CNT_W-1:0]  count;
    logic              wr_ack;
    logic              wr_err;
    logic              check_done;
    logic              win_valid;
    logic [CELL_W-1:0] win_player;
    logic [IDX_W-1:0]  row;
    logic [IDX_W-1:0]  col;
    logic [CELL_W-1:0] player;
    logic [1:0]        line_sel;
    logic [IDX_W-1:0]  step;
    logic              match;
    logic              hit;
    logic [ADDR_W-1:0] ptr;

    int                scan_idx;
    logic [ADDR_W-1:0] scan_addr;
    logic              on_line;
    logic              match_next;
    logic              hit_next;
    logic              wr_in_range;
    logic              rd_in_range;
    logic [CELL_W-1:0] target;
    logic              accept;
    logic [IDX_W-1:0]  wr_row;
    logic [IDX_W-1:0]  wr_col;

    // Cell visited this cycle: row, column, main diag, anti diag.
    always_comb begin
        scan_idx = 0;
        unique case (line_sel)
            2'd0:    scan_idx = int'(row) * N + int'(step);
            2'd1:    scan_idx = int'(step) * N + int'(col);
            2'd2:    scan_idx = int'(step) * N + int'(step);
            default: scan_idx = int'(step) * N + (N - 1 - int'(step));
        endcase
    end

    assign scan_addr = ADDR_W'(scan_idx);
    assign on_line = (line_sel == 2'd2) ? (row == col) :
                     (line_sel == 2'd3) ? (int'(row) + int'(col) == N - 1) :
                     1'b1;
    assign match_next = match && (cells[scan_addr] == player);
    assign hit_next = hit || (match_next && on_line);

    assign wr_in_range = int'(bus.wr_addr) < CELLS;
    assign rd_in_range = int'(bus.rd_addr) < CELLS;
    assign target = wr_in_range ? cells[bus.wr_addr] : '0;
    assign accept = wr_in_range && (bus.wr_data != '0) &&
                    (target == '0) && !win_valid;
    assign wr_row = IDX_W'(int'(bus.wr_addr) / N);
    assign wr_col = IDX_W'(int'(bus.wr_addr) % N);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            for (int i = 0; i < CELLS; i++) cells[i] <= '0;
            rd_data <= '0;
            count <= '0;
            wr_ack <= 1'b0;
            wr_err <= 1'b0;
            check_done <= 1'b0;
            win_valid <= 1'b0;
            win_player <= '0;
            row <= '0;
            col <= '0;
            player <= '0;
            line_sel <= '0;
            step <= '0;
            match <= 1'b0;
            hit <= 1'b0;
            ptr <= '0;
        end else begin
            wr_ack <= 1'b0;
            wr_err <= 1'b0;
            check_done <= 1'b0;
            rd_data <= rd_in_range ? cells[bus.rd_addr] : '0;
            unique case (state)
                IDLE: begin
                    if (bus.clr) begin
                        state <= CLEAR;
                        ptr <= '0;
                        win_valid <= 1'b0;
                        win_player <= '0;
                        wr_err <= bus.wr_req;
                    end else if (bus.wr_req) begin
                        if (accept) begin
                            cells[bus.wr_addr] <= bus.wr_data;
                            if (int'(count) < CELLS) count <= count + 1'b1;
                            wr_ack <= 1'b1;
                            row <= wr_row;
                            col <= wr_col;
                            player <= bus.wr_data;
                            line_sel <= 2'd0;
                            step <= '0;
                            match <= 1'b1;
                            hit <= 1'b0;
                            state <= CHECK;
                        end else begin
                            wr_err <= 1'b1;
                        end
                    end
                end
                CHECK: begin
                    wr_err <= bus.wr_req;
                    if (bus.clr) begin
                        state <= CLEAR;
                        ptr <= '0;
                        win_valid <= 1'b0;
                        win_player <= '0;
                    end else if (step == IDX_W'(N - 1)) begin
                        step <= '0;
                        match <= 1'b1;
                        hit <= hit_next;
                        if (line_sel == 2'd3) begin
                            check_done <= 1'b1;
                            state <= IDLE;
                            if (hit_next) begin
                                win_valid <= 1'b1;
                                win_player <= player;
                            end
                        end else begin
                            line_sel <= line_sel + 2'd1;
                        end
                    end else begin
                        step <= step + 1'b1;
                        match <= match_next;
                    end
                end
                CLEAR: begin
                    wr_err <= bus.wr_req;
                    cells[ptr] <= '0;
                    if (int'(ptr) == CELLS - 1) begin
                        count <= '0;
                        state <= IDLE;
                    end else begin
                        ptr <= ptr + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.rd_data = rd_data;
    assign bus.count = count;
    assign bus.full = (int'(count) == CELLS);
    assign bus.busy = (state != IDLE);
    assign bus.wr_ack = wr_ack;
    assign bus.wr_err = wr_err;
    assign bus.check_done = check_done;
    assign bus.win_valid = win_valid;
    assign bus.win_player = win_player;
endmodule

// File: tb/tb_game_board_memory.sv
// Scoreboard bench for game_board_memory on a 3x3 board with
// 2-bit player codes.
module tb_game_board_memory;
    logic clk = 1'b0;
    logic reset = 1'b0;

    game_board_memory_if #(.N(3), .CELL_W(2)) bus();

    game_board_memory #(.N(3), .CELL_W(2)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int    n_checks = 0;
    int    n_pass = 0;
    string tag_q[$];
    int    val_q[$];

    int    m_cell[9];
    int    m_count = 0;
    bit    m_win = 1'b0;
    int    m_player = 0;
    bit    m_busy = 1'b0;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic push(string tag, int val);
        tag_q.push_back(tag);
        val_q.push_back(val);
    endtask

    task automatic pop_chk(logic [31:0] got);
        string t;
        int v;
        if (tag_q.size() == 0) begin
            chk("sb_underflow", tag_q.size(), 1);
            return;
        end
        t = tag_q.pop_front();
        v = val_q.pop_front();
        chk(t, got, v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit model_win(int p);
        bit w = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (m_cell[3*i] == p && m_cell[3*i+1] == p && m_cell[3*i+2] == p)
                w = 1'b1;
            if (m_cell[i] == p && m_cell[i+3] == p && m_cell[i+6] == p)
                w = 1'b1;
        end
        if (m_cell[0] == p && m_cell[4] == p && m_cell[8] == p) w = 1'b1;
        if (m_cell[2] == p && m_cell[4] == p && m_cell[6] == p) w = 1'b1;
        return w;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 9; i++) m_cell[i] = 0;
        m_count = 0;
        m_win = 1'b0;
        m_player = 0;
        m_busy = 1'b0;
    endtask

    // Response code: 1 = wr_ack, 2 = wr_err.
    task automatic write(int addr, int data);
        bit ok;
        ok = !m_busy && addr < 9 && data != 0 && !m_win;
        if (ok) ok = (m_cell[addr] == 0);
        bus.wr_req = 1'b1;
        bus.wr_addr = 4'(addr);
        bus.wr_data = 2'(data);
        push($sformatf("wr_resp_a%0d_d%0d", addr, data), ok ? 1 : 2);
        tick();
        bus.wr_req = 1'b0;
        pop_chk({bus.wr_err, bus.wr_ack});
        if (ok) begin
            m_cell[addr] = data;
            m_count++;
            m_busy = 1'b1;
            if (model_win(data)) begin
                m_win = 1'b1;
                m_player = data;
            end
        end
    endtask

    task automatic wait_check(int n0);
        int n = n0;
        push("check_busy_len", 12);
        push("check_done", 1);
        push("win_valid", m_win);
        push("win_player", m_win ? m_player : 0);
        push("count", m_count);
        while (bus.busy && n < 200) begin
            tick();
            if (bus.busy) n++;
        end
        pop_chk(n);
        pop_chk(bus.check_done);
        pop_chk(bus.win_valid);
        pop_chk(bus.win_player);
        pop_chk(bus.count);
        m_busy = 1'b0;
    endtask

    task automatic do_clear();
        int n = 1;
        bit saw_done;
        bus.clr = 1'b1;
        tick();
        bus.clr = 1'b0;
        model_reset();
        push("clr_win_valid", 0);
        push("clr_busy_len", 9);
        push("clr_no_check_done", 0);
        push("clr_count", 0);
        pop_chk(bus.win_valid);
        saw_done = bus.check_done;
        while (bus.busy && n < 200) begin
            tick();
            saw_done |= bus.check_done;
            if (bus.busy) n++;
        end
        pop_chk(n);
        pop_chk(saw_done);
        pop_chk(bus.count);
    endtask

    task automatic read(int addr);
        bus.rd_addr = 4'(addr);
        push($sformatf("rd_%0d", addr), addr < 9 ? m_cell[addr] : 0);
        tick();
        pop_chk(bus.rd_data);
    endtask

    task automatic reset_state(string pfx);
        chk({pfx, "_busy"}, bus.busy, 0);
        chk({pfx, "_count"}, bus.count, 0);
        chk({pfx, "_full"}, bus.full, 0);
        chk({pfx, "_rd_data"}, bus.rd_data, 0);
        chk({pfx, "_ack_err"}, {bus.wr_ack, bus.wr_err}, 0);
        chk({pfx, "_check_done"}, bus.check_done, 0);
        chk({pfx, "_win"}, {bus.win_valid, bus.win_player}, 0);
    endtask

    initial begin
        bus.wr_req = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.clr = 1'b0;
        bus.rd_addr = '0;
        model_reset();
        repeat (2) tick();
        reset_state("rst");
        reset = 1'b1;
        tick();

        for (int i = 0; i < 9; i++) read(i);
        read(9);
        read(15);

        write(4, 1);
        wait_check(1);
        read(4);

        write(4, 2);
        write(9, 1);
        write(0, 0);
        read(4);
        chk("count_after_rejects", bus.count, m_count);

        write(0, 1);
        write(1, 2);
        wait_check(2);
        write(8, 1);
        wait_check(1);
        write(1, 2);
        chk("count_after_win", bus.count, m_count);

        do_clear();
        for (int i = 0; i < 9; i++) read(i);
        write(2, 2);
        wait_check(1);
        write(4, 2);
        wait_check(1);
        write(6, 2);
        wait_check(1);
        write(0, 1);

        do_clear();
        write(3, 3);
        wait_check(1);
        write(4, 3);
        wait_check(1);
        write(5, 3);
        wait_check(1);

        do_clear();
        begin
            int draw_addr[9] = '{0, 1, 2, 3, 4, 5, 6, 7, 8};
            int draw_val[9] = '{1, 2, 1, 1, 2, 2, 2, 1, 1};
            for (int i = 0; i < 9; i++) begin
                write(draw_addr[i], draw_val[i]);
                wait_check(1);
            end
        end
        chk("draw_full", bus.full, m_count == 9);
        chk("draw_count", bus.count, m_count);
        chk("draw_no_win", bus.win_valid, m_win);
        write(4, 1);
        chk("count_saturated", bus.count, m_count);
        read(7);

        do_clear();
        write(0, 1);
        repeat (3) tick();
        chk("mid_check_busy", bus.busy, 1);
        do_clear();
        read(0);

        write(0, 1);
        wait_check(1);
        bus.clr = 1'b1;
        tick();
        bus.clr = 1'b0;
        repeat (2) tick();
        chk("mid_clear_busy", bus.busy, 1);
        chk("mid_clear_count", bus.count, 1);
        #2;
        reset = 1'b0;
        #1;
        reset_state("async_rst");
        model_reset();
        #3;
        reset = 1'b1;
        tick();
        read(0);

        chk("sb_drain", tag_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end
endmodule
